// File: rtl/regfile_port_sched_pkg.sv
// Shared definitions for the register-file port scheduler:
// file geometry and the scheduler FSM encoding.
package regfile_port_sched_pkg;

    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = $clog2(RF_DEPTH);
    localparam int RF_DATA_W = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the preferred
// requester and moves to the other one after a grant.
// Ports: clk, reset (async high), req[1:0] in, gnt[1:0] out (one-hot/zero).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
        end else if (req[~ptr]) begin
            gnt[~ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_port_sched.sv
// Single-port scheduler in front of the 32x32 register file: arbitrates
// two readers and one writer onto one op per cycle, issues the post-reset
// clear, and routes registered read data back to the issuing reader.
// Ports: clk, reset (async high); rd_req_* / rd_resp_* reader side;
// wr_req_* writer side; rf_* register-file side; init_done status.
import regfile_port_sched_pkg::*;

module regfile_port_sched #(
    parameter int NUM_RD       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD-1:0]           rd_req_valid,
    output logic [NUM_RD-1:0]           rd_req_ready,
    input  logic [NUM_RD*RF_ADDR_W-1:0] rd_req_rs1,
    input  logic [NUM_RD*RF_ADDR_W-1:0] rd_req_rs2,
    output logic [NUM_RD-1:0]           rd_resp_valid,
    output logic [RF_DATA_W-1:0]        rd_resp_data1,
    output logic [RF_DATA_W-1:0]        rd_resp_data2,
    input  logic                        wr_req_valid,
    output logic                        wr_req_ready,
    input  logic [RF_ADDR_W-1:0]        wr_req_rd,
    input  logic [RF_DATA_W-1:0]        wr_req_data,
    output logic                        rf_en,
    output logic                        rf_reset,
    output logic                        rf_read_en,
    output logic                        rf_write_en,
    output logic [RF_ADDR_W-1:0]        rf_rs1,
    output logic [RF_ADDR_W-1:0]        rf_rs2,
    output logic [RF_ADDR_W-1:0]        rf_rd,
    output logic [RF_DATA_W-1:0]        rf_data_in,
    input  logic [RF_DATA_W-1:0]        rf_read_out1,
    input  logic [RF_DATA_W-1:0]        rf_read_out2,
    output logic                        init_done
);

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t state, state_nx;
    logic   run;

    logic [3:0]  starve_cnt;
    logic        rd_pend;
    logic        wr_win;
    logic [1:0]  arb_req;
    logic [1:0]  rd_gnt;
    logic        rd_acc;
    logic        gnt_id;

    logic [RF_ADDR_W-1:0] sel_rs1, sel_rs2;

    logic                 iss_rd_en, iss_wr_en;
    logic [RF_ADDR_W-1:0] iss_rs1, iss_rs2, iss_rd;
    logic [RF_DATA_W-1:0] iss_data;

    logic p0_v, p0_id, p1_v, p1_id;

    // FSM: INIT lasts exactly one cycle after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_INIT: state_nx = ST_RUN;
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_INIT;
        endcase
    end

    assign run       = (state == ST_RUN);
    assign init_done = run;

    // Clear pulse is gated so it stays low while reset is held.
    assign rf_reset = (state == ST_INIT) && !reset;

    // Write wins unless readers have waited STARVE_LIMIT write grants.
    assign rd_pend = |rd_req_valid;
    assign wr_win  = run && wr_req_valid && (starve_cnt < LIM);
    assign arb_req = (run && !wr_win) ? rd_req_valid : 2'b00;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .gnt   (rd_gnt)
    );

    assign rd_req_ready = rd_gnt;
    assign wr_req_ready = wr_win;
    assign rd_acc       = |rd_gnt;
    assign gnt_id       = rd_gnt[1];

    assign sel_rs1 = gnt_id ? rd_req_rs1[2*RF_ADDR_W-1:RF_ADDR_W]
                            : rd_req_rs1[RF_ADDR_W-1:0];
    assign sel_rs2 = gnt_id ? rd_req_rs2[2*RF_ADDR_W-1:RF_ADDR_W]
                            : rd_req_rs2[RF_ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (wr_win && rd_pend) begin
            if (starve_cnt >= LIM) begin
                starve_cnt <= LIM;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (rd_acc || !rd_pend) begin
            starve_cnt <= 4'd0;
        end
    end

    // Issue stage; writes to x0 are accepted but dropped here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_rd_en <= 1'b0;
            iss_wr_en <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_data  <= '0;
        end else begin
            iss_rd_en <= rd_acc;
            iss_wr_en <= wr_win && (wr_req_rd != '0);
            iss_rs1   <= rd_acc ? sel_rs1 : '0;
            iss_rs2   <= rd_acc ? sel_rs2 : '0;
            if (wr_win && (wr_req_rd != '0)) begin
                iss_rd   <= wr_req_rd;
                iss_data <= wr_req_data;
            end else begin
                iss_rd   <= '0;
                iss_data <= '0;
            end
        end
    end

    assign rf_en       = iss_rd_en | iss_wr_en | rf_reset;
    assign rf_read_en  = iss_rd_en;
    assign rf_write_en = iss_wr_en;
    assign rf_rs1      = iss_rs1;
    assign rf_rs2      = iss_rs2;
    assign rf_rd       = iss_rd;
    assign rf_data_in  = iss_data;

    // Stage 0 tracks the issue cycle, stage 1 the file-output cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_v  <= 1'b0;
            p0_id <= 1'b0;
            p1_v  <= 1'b0;
            p1_id <= 1'b0;
        end else begin
            p0_v  <= rd_acc;
            p0_id <= gnt_id;
            p1_v  <= p0_v;
            p1_id <= p0_id;
        end
    end

    always_comb begin
        rd_resp_valid = '0;
        if (p1_v) begin
            rd_resp_valid[p1_id] = 1'b1;
        end
    end

    assign rd_resp_data1 = rf_read_out1;
    assign rd_resp_data2 = rf_read_out2;

endmodule

// File: doc/regfile_port_sched.md
# regfile_port_sched

Single-port scheduler in front of the 32×32 register file. Arbitrates two read requesters (each reading an rs1/rs2 pair) and one write requester onto the file's one-operation-per-cycle port, which serves either a read or a write in a given cycle. It sequences the file's synchronous clear after reset and routes registered read data back to the requester that issued the read. It sits between decode/operand-fetch and writeback on one side and the register file on the other.

## Interface
- `NUM_RD`, 2: number of read requesters; RTL is written for 2.
- `STARVE_LIMIT`, 4: maximum consecutive write grants while any read is pending; range 1–15.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rd_req_valid`  in  NUM_RD  read request per requester.
- `rd_req_ready`  out  NUM_RD  read accepted this cycle; one-hot or zero.
- `rd_req_rs1`, `rd_req_rs2`  in  NUM_RD×5  packed addresses; requester i uses bits [5i+4:5i].
- `rd_resp_valid`  out  NUM_RD  response strobe, one-hot or zero.
- `rd_resp_data1`, `rd_resp_data2`  out  32 each  shared response data, valid with `rd_resp_valid`.
- `wr_req_valid`  in  1  write request.
- `wr_req_ready`  out  1  write accepted.
- `wr_req_rd`  in  5  write address.
- `wr_req_data`  in  32  write data.
- `rf_en`, `rf_reset`, `rf_read_en`, `rf_write_en`  out  1 each  register-file controls.
- `rf_rs1`, `rf_rs2`, `rf_rd`  out  5 each  register-file addresses.
- `rf_data_in`  out  32  register-file write data.
- `rf_read_out1`, `rf_read_out2`  in  32 each  register-file read data, registered inside the file.
- `init_done`  out  1  high once the file clear has been issued.

## Operation
- FSM states:
  - INIT: entered on reset. Drives `rf_en`=1 and `rf_reset`=1 for exactly one cycle. All ready signals are 0. Always moves to RUN.
  - RUN: `init_done`=1; arbitrates every cycle.
- Handshake: a request is accepted on any edge where valid and ready are both high. Ready is combinational from the current grant. Valid may not be withdrawn before acceptance, and request fields must hold until then.
- Grant priority in RUN:
  1. Write wins if `wr_req_valid` and `starve_cnt` < `STARVE_LIMIT`.
  2. Otherwise reads win. Between the two readers, round-robin: `rr_ptr` names the preferred requester and flips to the other after that requester is granted. The pointer is unchanged on write grants or idle cycles.
- `starve_cnt` (4 bits):
  - Increments on a write grant while any read is pending.
  - Clears on a read grant or when no read is pending.
  - Saturates at `STARVE_LIMIT`.
- Writes to `rd`=0 are accepted but not issued: `rf_write_en` stays 0. x0 is never written.
- Issue stage: an accepted op is registered and drives the `rf_*` pins for the following cycle with `rf_en`=1. Only one of `rf_read_en`/`rf_write_en` is high in any cycle. Idle cycles drive `rf_en`=0.
- Response tracking: a 2-deep pipeline carries {valid, requester id}. `rd_resp_valid[id]` asserts in the cycle the file's outputs hold the new data. `rd_resp_data*` pass through `rf_read_out*` combinationally.
- Ordering: single issue. A read accepted after a write to the same register returns the new value; no forwarding is needed.

## Timing
- Reset values: all ready/valid outputs 0, `rf_en`/`rf_read_en`/`rf_write_en` 0, `rf_reset` 0, addresses and data 0, `init_done` 0, `rr_ptr`=0, `starve_cnt`=0.
- After `reset` falls: the INIT cycle (`rf_reset` high) is cycle 1, RUN starts at cycle 2, first acceptance is possible at cycle 2.
- Read latency: accept at edge T, `rf_read_en` high in cycle T+1, `rd_resp_valid` high in cycle T+2. Throughput is one op per cycle.
- Write: accept at edge T, `rf_write_en` high in cycle T+1, file updated at the end of T+1.
- Reset asserted mid-operation: in-flight responses are dropped with no `rd_resp_valid`, the issue stage is cleared immediately (asynchronously), and INIT repeats.

## Structure
- Shared package holds: `RF_ADDR_W`=5, `RF_DATA_W`=32, `RF_DEPTH`=32, and the FSM state encoding (INIT, RUN).
- One sub-module, `rr_arbiter2`: 2-way round-robin grant with pointer update. The write/starvation logic stays in the top level.

## Test plan
- Reset release with no requests -> `rf_en`=`rf_reset`=1 for exactly one cycle, `init_done` rises the next cycle, all other `rf_*` controls 0.
- Write x5=0xDEADBEEF, then requester 0 reads rs1=5, rs2=0 on the following cycle -> `rd_resp_valid`=01 two cycles after acceptance, data1=0xDEADBEEF, data2=0.
- Write x0=0x1234 -> `wr_req_ready` pulses, `rf_write_en` never asserts; a later read of x0 returns 0.
- Both readers valid for 4 cycles -> grants alternate 0,1,0,1 and each response returns with the correct id.
- Write valid continuously and reader 1 valid, `STARVE_LIMIT`=4 -> exactly 4 write grants, then reader 1 is granted, then writes resume.
- Reset asserted one cycle after a read is accepted -> no `rd_resp_valid`, INIT replays, and a post-reset read of any register returns 0.
